// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: miss-side refill engine for the instruction cache.
// It takes a missed word PC and issues one word read at a time to the memory
// network. Each returned instruction is written into the icache write port.
// When the refill finishes, it pulses refill_done_o.
// Optional feature macro: ICACHE_REFILL_PREFETCH_EN. When it is defined, each
// miss fetches prefetch_words_p consecutive words. When it is undefined, each
// miss fetches a single word.
module icache_refill_ctrl #(
  parameter int icache_tag_width_p  = 4,
  parameter int icache_addr_width_p = 8,
  parameter int pc_width_lp         = icache_tag_width_p + icache_addr_width_p,
  parameter int prefetch_words_p    = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           miss_v_i,
  input  logic [pc_width_lp-1:0]         miss_pc_i,
  input  logic                           flush_i,
  output logic                           mem_req_v_o,
  output logic [pc_width_lp-1:0]         mem_req_addr_o,
  input  logic                           mem_req_ready_i,
  input  logic                           mem_resp_v_i,
  input  logic [31:0]                    mem_resp_data_i,
  output logic                           icache_w_en_o,
  output logic [icache_addr_width_p-1:0] icache_w_addr_o,
  output logic [icache_tag_width_p-1:0]  icache_w_tag_o,
  output logic [31:0]                    icache_w_instr_o,
  output logic                           busy_o,
  output logic                           refill_done_o
);

  // Reject a prefetch depth that is not a power of two of at least 2.
  if ((prefetch_words_p < 2) || ((prefetch_words_p & (prefetch_words_p - 1)) != 0)) begin : g_bad_prefetch
    $error("icache_refill_ctrl: prefetch_words_p must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    DRAIN = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [pc_width_lp-1:0] addr_q, addr_d;
  logic [31:0]            data_q, data_d;

`ifdef ICACHE_REFILL_PREFETCH_EN
  localparam int cnt_width_lp = $clog2(prefetch_words_p);
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;

  // Words-remaining counter. It exists only when prefetch is compiled in.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= {cnt_width_lp{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // State and datapath registers. An asynchronous reset clears every bus to 0.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      addr_q  <= {pc_width_lp{1'b0}};
      data_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Next-state and datapath update. flush_i overrides every other transition.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef ICACHE_REFILL_PREFETCH_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (miss_v_i) begin
          addr_d  = miss_pc_i;
`ifdef ICACHE_REFILL_PREFETCH_EN
          cnt_d   = cnt_width_lp'(prefetch_words_p - 1);
`endif
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (flush_i) begin
          // Once the request is accepted, its response must still be drained.
          state_d = mem_req_ready_i ? DRAIN : IDLE;
        end else if (mem_req_ready_i) begin
          state_d = WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (flush_i) begin
          state_d = mem_resp_v_i ? IDLE : DRAIN;
        end else if (mem_resp_v_i) begin
          data_d  = mem_resp_data_i;
          state_d = WRITE;
        end else begin
          state_d = WAIT;
        end
      end
      WRITE: begin
        if (flush_i) begin
          state_d = IDLE;
`ifdef ICACHE_REFILL_PREFETCH_EN
        end else if (cnt_q != {cnt_width_lp{1'b0}}) begin
          // The next word address wraps modulo 2^pc_width_lp; no alignment.
          addr_d  = addr_q + pc_width_lp'(1);
          cnt_d   = cnt_q - cnt_width_lp'(1);
          state_d = REQ;
`endif
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      DRAIN: begin
        if (mem_resp_v_i) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  logic req_v_s, w_en_s, busy_s, done_s;

  // Output decode. It depends only on the state register.
  always_comb begin
    req_v_s = 1'b0;
    w_en_s  = 1'b0;
    busy_s  = 1'b1;
    done_s  = 1'b0;
    case (state_q)
      IDLE:    busy_s  = 1'b0;
      REQ:     req_v_s = 1'b1;
      WAIT:    busy_s  = 1'b1;
      WRITE:   w_en_s  = 1'b1;
      DONE:    done_s  = 1'b1;
      DRAIN:   busy_s  = 1'b1;
      default: busy_s  = 1'b0;
    endcase
  end

  assign mem_req_v_o      = req_v_s;
  assign mem_req_addr_o   = addr_q;
  assign icache_w_en_o    = w_en_s;
  assign icache_w_addr_o  = addr_q[icache_addr_width_p-1:0];
  assign icache_w_tag_o   = addr_q[pc_width_lp-1:icache_addr_width_p];
  assign icache_w_instr_o = data_q;
  assign busy_o           = busy_s;
  assign refill_done_o    = done_s;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed self-checking bench for icache_refill_ctrl (8-bit index, 4-bit tag).
module tb_icache_refill_ctrl;

`ifdef ICACHE_REFILL_PREFETCH_EN
  localparam int nw = 4;
`else
  localparam int nw = 1;
`endif

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        miss_v_i;
  logic [11:0] miss_pc_i;
  logic        flush_i;
  logic        mem_req_v_o;
  logic [11:0] mem_req_addr_o;
  logic        mem_req_ready_i;
  logic        mem_resp_v_i;
  logic [31:0] mem_resp_data_i;
  logic        icache_w_en_o;
  logic [7:0]  icache_w_addr_o;
  logic [3:0]  icache_w_tag_o;
  logic [31:0] icache_w_instr_o;
  logic        busy_o;
  logic        refill_done_o;

  int checks = 0;
  int failures = 0;

  icache_refill_ctrl #(
    .icache_tag_width_p (4),
    .icache_addr_width_p(8),
    .prefetch_words_p   (4)
  ) dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .miss_v_i        (miss_v_i),
    .miss_pc_i       (miss_pc_i),
    .flush_i         (flush_i),
    .mem_req_v_o     (mem_req_v_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_resp_v_i    (mem_resp_v_i),
    .mem_resp_data_i (mem_resp_data_i),
    .icache_w_en_o   (icache_w_en_o),
    .icache_w_addr_o (icache_w_addr_o),
    .icache_w_tag_o  (icache_w_tag_o),
    .icache_w_instr_o(icache_w_instr_o),
    .busy_o          (busy_o),
    .refill_done_o   (refill_done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"},  32'(busy_o), 32'd0);
    chk({tag, "_req_v"}, 32'(mem_req_v_o), 32'd0);
    chk({tag, "_w_en"},  32'(icache_w_en_o), 32'd0);
    chk({tag, "_done"},  32'(refill_done_o), 32'd0);
  endtask

  // Full refill starting at pc; each request is stalled for 'delay' cycles,
  // during which an extra (to be ignored) miss is presented.
  task automatic refill(input logic [11:0] pc, input logic [31:0] d0, input int delay);
    logic [11:0] a;
    miss_v_i = 1'b1; miss_pc_i = pc; tick(); miss_v_i = 1'b0;
    for (int w = 0; w < nw; w++) begin
      a = pc + 12'(w);
      for (int d = 0; d < delay; d++) begin
        chk("bp_req_v", 32'(mem_req_v_o), 32'd1);
        chk("bp_req_addr", 32'(mem_req_addr_o), 32'(a));
        miss_v_i = 1'b1; miss_pc_i = 12'hABC; mem_req_ready_i = 1'b0; tick();
      end
      miss_v_i = 1'b0;
      chk("req_v", 32'(mem_req_v_o), 32'd1);
      chk("req_addr", 32'(mem_req_addr_o), 32'(a));
      chk("req_busy", 32'(busy_o), 32'd1);
      mem_req_ready_i = 1'b1; tick(); mem_req_ready_i = 1'b0;
      chk("wait_req_v", 32'(mem_req_v_o), 32'd0);
      chk("wait_w_en", 32'(icache_w_en_o), 32'd0);
      mem_resp_v_i = 1'b1; mem_resp_data_i = d0 + 32'(w); tick(); mem_resp_v_i = 1'b0;
      chk("wr_en", 32'(icache_w_en_o), 32'd1);
      chk("wr_addr", 32'(icache_w_addr_o), 32'(a[7:0]));
      chk("wr_tag", 32'(icache_w_tag_o), 32'(a[11:8]));
      chk("wr_instr", icache_w_instr_o, d0 + 32'(w));
      chk("wr_done", 32'(refill_done_o), 32'd0);
      tick();
    end
    chk("done_pulse", 32'(refill_done_o), 32'd1);
    chk("done_w_en", 32'(icache_w_en_o), 32'd0);
    chk("done_busy", 32'(busy_o), 32'd1);
    tick();
    check_idle("after_done");
  endtask

  initial begin
    reset_n_i = 1'b0; miss_v_i = 1'b0; miss_pc_i = 12'h000; flush_i = 1'b0;
    mem_req_ready_i = 1'b0; mem_resp_v_i = 1'b0; mem_resp_data_i = 32'h0;
    #1;
    check_idle("rst0");
    chk("rst0_addr", 32'(mem_req_addr_o), 32'd0);
    chk("rst0_instr", icache_w_instr_o, 32'd0);
    tick(); tick();
    reset_n_i = 1'b1;
    tick();
    check_idle("post_rst");

    // Single miss at 0x123: the first write goes to index 0x23 with tag 0x1.
    miss_v_i = 1'b1; miss_pc_i = 12'h123; tick(); miss_v_i = 1'b0;
    chk("t1_c1_req_v", 32'(mem_req_v_o), 32'd1);
    chk("t1_c1_busy", 32'(busy_o), 32'd1);
    chk("t1_c1_addr", 32'(mem_req_addr_o), 32'h123);
    mem_req_ready_i = 1'b1; tick(); mem_req_ready_i = 1'b0;
    mem_resp_v_i = 1'b1; mem_resp_data_i = 32'hDEAD_BEEF; tick(); mem_resp_v_i = 1'b0;
    chk("t1_c3_w_en", 32'(icache_w_en_o), 32'd1);
    chk("t1_c3_w_addr", 32'(icache_w_addr_o), 32'h23);
    chk("t1_c3_w_tag", 32'(icache_w_tag_o), 32'h1);
    chk("t1_c3_instr", icache_w_instr_o, 32'hDEAD_BEEF);
    if (nw > 1) begin
      // Let the remaining prefetched words complete with immediate handshakes.
      for (int w = 1; w < nw; w++) begin
        tick(); mem_req_ready_i = 1'b1; tick(); mem_req_ready_i = 1'b0;
        mem_resp_v_i = 1'b1; tick(); mem_resp_v_i = 1'b0;
        chk("t1_pf_w_en", 32'(icache_w_en_o), 32'd1);
      end
    end
    tick();
    chk("t1_c4_done", 32'(refill_done_o), 32'd1);
    chk("t1_c4_busy", 32'(busy_o), 32'd1);
    tick();
    check_idle("t1_c5");

    // Crossing a tag boundary and wrapping the PC (prefetch covers all words).
    refill(12'h0FE, 32'h1000_0000, 0);
    refill(12'hFFF, 32'h2000_0000, 0);
    // Backpressure for 5 cycles with a stray miss presented meanwhile.
    refill(12'h3A7, 32'h3000_0000, 5);

    // A response while idle is a protocol error and is ignored.
    mem_resp_v_i = 1'b1; tick(); mem_resp_v_i = 1'b0;
    check_idle("stray_resp");

    // Flush in REQ before the handshake drops straight to IDLE.
    miss_v_i = 1'b1; miss_pc_i = 12'h200; tick(); miss_v_i = 1'b0;
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    check_idle("fl_req");

    // Flush on the handshake cycle drains the one outstanding response.
    miss_v_i = 1'b1; miss_pc_i = 12'h210; tick(); miss_v_i = 1'b0;
    mem_req_ready_i = 1'b1; flush_i = 1'b1; tick(); mem_req_ready_i = 1'b0; flush_i = 1'b0;
    chk("fl_hs_busy", 32'(busy_o), 32'd1);
    chk("fl_hs_req_v", 32'(mem_req_v_o), 32'd0);
    mem_resp_v_i = 1'b1; tick(); mem_resp_v_i = 1'b0;
    check_idle("fl_hs_end");

    // Flush in WAIT together with the response discards it.
    miss_v_i = 1'b1; miss_pc_i = 12'h220; tick(); miss_v_i = 1'b0;
    mem_req_ready_i = 1'b1; tick(); mem_req_ready_i = 1'b0;
    flush_i = 1'b1; mem_resp_v_i = 1'b1; tick(); flush_i = 1'b0; mem_resp_v_i = 1'b0;
    check_idle("fl_wait_resp");

    // Flush in WAIT with the response 4 cycles later, handled through DRAIN.
    miss_v_i = 1'b1; miss_pc_i = 12'h230; tick(); miss_v_i = 1'b0;
    mem_req_ready_i = 1'b1; tick(); mem_req_ready_i = 1'b0;
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drain_busy", 32'(busy_o), 32'd1);
      chk("drain_w_en", 32'(icache_w_en_o), 32'd0);
      chk("drain_done", 32'(refill_done_o), 32'd0);
      tick();
    end
    chk("drain_busy_resp", 32'(busy_o), 32'd1);
    mem_resp_v_i = 1'b1; mem_resp_data_i = 32'hBAD0_BAD0; tick(); mem_resp_v_i = 1'b0;
    check_idle("drain_end");
    tick();
    check_idle("drain_end2");

    // Reset while in WAIT, followed by a stale response and then a normal refill.
    miss_v_i = 1'b1; miss_pc_i = 12'h455; tick(); miss_v_i = 1'b0;
    mem_req_ready_i = 1'b1; tick(); mem_req_ready_i = 1'b0;
    #2 reset_n_i = 1'b0;
    #1;
    check_idle("rst_mid");
    chk("rst_mid_req_addr", 32'(mem_req_addr_o), 32'd0);
    chk("rst_mid_w_addr", 32'(icache_w_addr_o), 32'd0);
    chk("rst_mid_w_tag", 32'(icache_w_tag_o), 32'd0);
    chk("rst_mid_instr", icache_w_instr_o, 32'd0);
    tick();
    reset_n_i = 1'b1;
    mem_resp_v_i = 1'b1; mem_resp_data_i = 32'h5555_AAAA; tick(); mem_resp_v_i = 1'b0;
    check_idle("stale_resp");
    chk("stale_instr", icache_w_instr_o, 32'd0);
    refill(12'h321, 32'h4000_0000, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
